// File: rtl/ecc_protocol_checker_if.sv
// ---------------------------------------------------------------------------
// ecc_protocol_checker_if
// Result-side signals of the ECC EncDec core as seen by the protocol checker.
//   op_start        : one-cycle strobe, core accepted a new operation
//   op_mode         : operation mode, meaningful with op_start
//                     (0 encode, 1 decode, 2 full, 3 reserved)
//   data_out        : core result word
//   operation_done  : core completion strobe
//   num_of_errors   : error count reported alongside operation_done
// Modports:
//   master : the EncDec core (drives everything)
//   slave  : the checker (observes everything)
// ---------------------------------------------------------------------------
interface ecc_protocol_checker_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  op_start;
  logic [1:0]            op_mode;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  operation_done;
  logic [1:0]            num_of_errors;

  modport master (
    output op_start,
    output op_mode,
    output data_out,
    output operation_done,
    output num_of_errors
  );

  modport slave (
    input op_start,
    input op_mode,
    input data_out,
    input operation_done,
    input num_of_errors
  );
endinterface

// File: rtl/ecc_protocol_checker.sv
// ---------------------------------------------------------------------------
// ecc_protocol_checker
// Runtime protocol checker placed beside the ECC EncDec core. It tracks the
// outstanding operation and records rule violations:
//   R0 activity on the result interface right after reset (POST_RST)
//   R1 no completion within TIMEOUT cycles of op_start (inclusive deadline)
//   R2 operation_done while no operation is outstanding
//   R3 operation_done high on two consecutive cycles
//   R4 completion reporting num_of_errors == 3
//   R5 encode completion reporting num_of_errors != 0
//   R6 op_start while an operation is outstanding and not completing
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   chk_en      : 1 = record violations, 0 = track only
//   clr         : synchronous clear of violation, ops_cnt, viol_cnt
//   mon         : observed core signals (slave modport)
//   busy        : operation outstanding
//   violation   : sticky per-rule flags, bit n = rule Rn
//   viol_pulse  : one-cycle flag after any cycle with a recorded violation
//   ops_cnt     : accepted completions, saturating
//   viol_cnt    : cycles with at least one recorded violation, saturating
// ---------------------------------------------------------------------------
module ecc_protocol_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chk_en,
  input  logic                  clr,
  ecc_protocol_checker_if.slave mon,
  output logic                  busy,
  output logic [6:0]            violation,
  output logic                  viol_pulse,
  output logic [CNT_WIDTH-1:0]  ops_cnt,
  output logic [CNT_WIDTH-1:0]  viol_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    POST_RST = 2'd0,
    IDLE     = 2'd1,
    WAIT     = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      mode_q, mode_d;
  logic            done_p1;
  logic            accept;
  logic [6:0]      rules;
  logic [6:0]      rec;
  logic            rec_any;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // ---- stage 0: rule evaluation and next-state logic ----
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    mode_d  = mode_q;
    rules   = '0;

    // A done that is the second cycle of a held strobe is not a completion.
    accept = (state_q == WAIT) && mon.operation_done && !done_p1;

    rules[0] = (state_q == POST_RST) &&
               ((mon.data_out != '0) || mon.operation_done || (mon.num_of_errors != 2'd0));
    rules[1] = (state_q == WAIT) && !accept && (timer_q == TW'(TIMEOUT));
    rules[2] = (state_q != WAIT) && mon.operation_done;
    rules[3] = mon.operation_done && done_p1;
    rules[4] = accept && (mon.num_of_errors == 2'd3);
    rules[5] = accept && (mode_q == 2'd0) && (mon.num_of_errors != 2'd0);
    rules[6] = (state_q == WAIT) && mon.op_start && !mon.operation_done;

    // A new op always (re)starts tracking, whatever happened to the old one.
    if (mon.op_start) begin
      state_d = WAIT;
      timer_d = TW'(1);
      mode_d  = mon.op_mode;
    end else if (state_q == WAIT) begin
      if (accept || rules[1]) begin
        state_d = IDLE;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  assign busy    = (state_q == WAIT);
  assign rec     = chk_en ? rules : 7'd0;
  assign rec_any = |rec;

  // ---- stage 1: tracking state ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= POST_RST;
      timer_q <= '0;
      mode_q  <= 2'd0;
      done_p1 <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      mode_q  <= mode_d;
      done_p1 <= mon.operation_done;
    end
  end

  // ---- stage 1: violation recording ----
  // On clr the current cycle's events are kept so nothing is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      violation  <= 7'd0;
      viol_pulse <= 1'b0;
      ops_cnt    <= '0;
      viol_cnt   <= '0;
    end else begin
      viol_pulse <= rec_any;
      if (clr) begin
        violation <= rec;
        viol_cnt  <= {{(CNT_WIDTH-1){1'b0}}, rec_any};
        ops_cnt   <= {{(CNT_WIDTH-1){1'b0}}, accept};
      end else begin
        violation <= violation | rec;
        if (rec_any) viol_cnt <= sat_inc(viol_cnt);
        if (accept)  ops_cnt  <= sat_inc(ops_cnt);
      end
    end
  end

endmodule

// File: tb/tb_ecc_protocol_checker.sv
module tb_ecc_protocol_checker;
  localparam int DW = 32;
  localparam int TO = 64;
  localparam int CW = 16;
  localparam longint CMAX = (64'd1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, chk_en, clr;
  logic          busy, viol_pulse;
  logic [6:0]    violation;
  logic [CW-1:0] ops_cnt, viol_cnt;

  ecc_protocol_checker_if #(.DATA_WIDTH(DW)) bus();

  ecc_protocol_checker #(.DATA_WIDTH(DW), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .chk_en     (chk_en),
    .clr        (clr),
    .mon        (bus.slave),
    .busy       (busy),
    .violation  (violation),
    .viol_pulse (viol_pulse),
    .ops_cnt    (ops_cnt),
    .viol_cnt   (viol_cnt)
  );

  typedef struct {
    logic          busy;
    logic [6:0]    viol;
    logic          pulse;
    logic [CW-1:0] ops;
    logic [CW-1:0] vc;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  bit rst_req = 1'b0;
  bit en_req  = 1'b1;
  bit clr_req = 1'b0;

  // Reference model: an outstanding op is just "pending since cycle m_start".
  int         cyc = 0;
  bit         m_post, m_pend, m_prev_done;
  int         m_start;
  logic [1:0] m_mode;
  exp_t       m;

  function automatic logic [CW-1:0] bump(input logic [CW-1:0] v, input bit inc);
    longint n;
    n = longint'(v);
    if (inc && n < CMAX) n = n + 1;
    return n[CW-1:0];
  endfunction

  task automatic model_step(input bit op_s, input logic [1:0] md, input logic [DW-1:0] d,
                            input bit dn, input logic [1:0] ne);
    int         age;
    bit         acc, timed_out;
    logic [6:0] r, rec;
    cyc++;
    if (!rst_req) begin
      m_post = 1; m_pend = 0; m_prev_done = 0; m_start = 0; m_mode = 2'd0;
      m.viol = 7'd0; m.pulse = 1'b0; m.ops = '0; m.vc = '0;
    end else begin
      age       = cyc - m_start;
      acc       = m_pend && dn && !m_prev_done;
      timed_out = m_pend && !acc && (age == TO);
      r = 7'd0;
      if (m_post && (d != 0 || dn || ne != 0)) r[0] = 1;
      if (timed_out)                          r[1] = 1;
      if (!m_pend && dn)                      r[2] = 1;
      if (dn && m_prev_done)                  r[3] = 1;
      if (acc && ne == 2'd3)                  r[4] = 1;
      if (acc && m_mode == 2'd0 && ne != 0)   r[5] = 1;
      if (m_pend && op_s && !dn)              r[6] = 1;
      if (op_s) begin
        m_pend = 1; m_post = 0; m_start = cyc; m_mode = md;
      end else if (acc || timed_out) begin
        m_pend = 0;
      end
      m_prev_done = dn;
      rec = en_req ? r : 7'd0;
      m.pulse = |rec;
      if (clr_req) begin
        m.viol = rec;
        m.vc   = (|rec) ? CW'(1) : CW'(0);
        m.ops  = acc ? CW'(1) : CW'(0);
      end else begin
        m.viol = m.viol | rec;
        m.vc   = bump(m.vc, |rec);
        m.ops  = bump(m.ops, acc);
      end
    end
    m.busy = m_pend;
    m.cyc  = cyc;
    exp_q.push_back(m);
  endtask

  task automatic cycle(input bit op_s, input logic [1:0] md, input logic [DW-1:0] d,
                       input bit dn, input logic [1:0] ne);
    @(negedge clk);
    rst                = rst_req;
    chk_en             = en_req;
    clr                = clr_req;
    bus.op_start       = op_s;
    bus.op_mode        = md;
    bus.data_out       = d;
    bus.operation_done = dn;
    bus.num_of_errors  = ne;
    model_step(op_s, md, d, dn, ne);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, '0, 1'b0, 2'd0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", nm, act, expv);
    end
  endtask

  task automatic reset_pulse();
    rst_req = 1'b0; idle(2);
    rst_req = 1'b1;
  endtask

  task automatic do_clr();
    clr_req = 1'b1; idle(1); clr_req = 1'b0;
  endtask

  // Scoreboard monitor: every active edge has one expected record queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (busy !== e.busy || violation !== e.viol || viol_pulse !== e.pulse ||
            ops_cnt !== e.ops || viol_cnt !== e.vc) begin
          failures++;
          $display("FAIL scoreboard cyc=%0d got busy=%b viol=%h pulse=%b ops=%0d vcnt=%0d exp busy=%b viol=%h pulse=%b ops=%0d vcnt=%0d",
                   e.cyc, busy, violation, viol_pulse, ops_cnt, viol_cnt,
                   e.busy, e.viol, e.pulse, e.ops, e.vc);
        end
      end
    end
  end

  initial begin
    bit         op_s, dn;
    logic [1:0] md, ne;
    logic [DW-1:0] d;

    rst = 1'b0; chk_en = 1'b1; clr = 1'b0;
    bus.op_start = 0; bus.op_mode = 0; bus.data_out = '0;
    bus.operation_done = 0; bus.num_of_errors = 0;

    // Reset and a clean decode operation
    reset_pulse();
    settle();
    chk("reset_busy", busy, 0);
    chk("reset_viol", violation, 0);
    idle(2);
    cycle(1, 2'd1, '0, 0, 2'd0);
    settle();
    chk("busy_after_start", busy, 1);
    idle(4);
    cycle(0, 2'd0, '0, 1, 2'd1);
    settle();
    chk("clean_viol", violation, 0);
    chk("clean_ops", ops_cnt, 1);
    chk("clean_busy", busy, 0);

    // Timeout, then a late done
    cycle(1, 2'd1, '0, 0, 2'd0);
    idle(64);
    settle();
    chk("timeout_viol", violation, 7'h02);
    chk("timeout_pulse", viol_pulse, 1);
    chk("timeout_vcnt", viol_cnt, 1);
    idle(5);
    cycle(0, 2'd0, '0, 1, 2'd0);
    settle();
    chk("late_done_viol", violation, 7'h06);
    chk("late_done_vcnt", viol_cnt, 2);
    do_clr();
    cycle(1, 2'd1, '0, 0, 2'd0);
    idle(63);
    cycle(0, 2'd0, '0, 1, 2'd0);
    settle();
    chk("deadline_viol", violation, 0);
    chk("deadline_ops", ops_cnt, 1);

    // Error-count rules
    do_clr();
    cycle(1, 2'd0, '0, 0, 2'd0);
    idle(2);
    cycle(0, 2'd0, '0, 1, 2'd2);
    settle();
    chk("r5_viol", violation, 7'h20);
    cycle(1, 2'd1, '0, 0, 2'd0);
    idle(2);
    cycle(0, 2'd0, '0, 1, 2'd3);
    settle();
    chk("r4_viol", violation, 7'h30);
    chk("r4_ops", ops_cnt, 2);

    // Back-to-back, overlapping start, held done
    do_clr();
    cycle(1, 2'd1, '0, 0, 2'd0);
    idle(2);
    cycle(1, 2'd1, '0, 1, 2'd0);
    settle();
    chk("b2b_busy", busy, 1);
    chk("b2b_viol", violation, 0);
    idle(1);
    cycle(1, 2'd1, '0, 0, 2'd0);
    settle();
    chk("r6_viol", violation, 7'h40);
    cycle(0, 2'd0, '0, 1, 2'd0);
    cycle(0, 2'd0, '0, 1, 2'd0);
    settle();
    chk("r3_viol", violation, 7'h4C);
    chk("r3_ops", ops_cnt, 2);

    // Post-reset activity, masking, clear racing a violation
    reset_pulse();
    cycle(0, 2'd0, 32'hDEADBEEF, 0, 2'd0);
    settle();
    chk("r0_viol", violation, 7'h01);
    en_req = 1'b0;
    reset_pulse();
    cycle(0, 2'd0, 32'hDEADBEEF, 0, 2'd0);
    settle();
    chk("masked_viol", violation, 0);
    chk("masked_vcnt", viol_cnt, 0);
    en_req = 1'b1;
    reset_pulse();
    cycle(1, 2'd0, '0, 0, 2'd0);
    cycle(0, 2'd0, '0, 1, 2'd1);
    idle(1);
    clr_req = 1'b1;
    cycle(0, 2'd0, '0, 1, 2'd0);
    clr_req = 1'b0;
    settle();
    chk("clr_r2_viol", violation, 7'h04);
    chk("clr_r2_vcnt", viol_cnt, 1);
    chk("clr_r2_ops", ops_cnt, 0);

    // Reset in the middle of an operation
    cycle(1, 2'd1, '0, 0, 2'd0);
    idle(9);
    rst_req = 1'b0;
    idle(1);
    settle();
    chk("midrst_busy", busy, 0);
    chk("midrst_viol", violation, 0);
    chk("midrst_ops", ops_cnt, 0);
    rst_req = 1'b1;
    cycle(0, 2'd0, '0, 1, 2'd0);
    settle();
    chk("midrst_done_viol", violation, 7'h05);

    // Counter saturation
    reset_pulse();
    for (int i = 0; i < 65540; i++) cycle(0, 2'd0, 32'hDEADBEEF, 0, 2'd0);
    settle();
    chk("vcnt_saturate", viol_cnt, 16'hFFFF);

    // Randomized traffic against the reference model
    reset_pulse();
    for (int i = 0; i < 3000; i++) begin
      rst_req = ($urandom_range(0, 499) != 0);
      en_req  = ($urandom_range(0, 19) != 0);
      clr_req = ($urandom_range(0, 199) == 0);
      op_s    = ($urandom_range(0, 15) == 0);
      md      = 2'($urandom_range(0, 3));
      ne      = 2'($urandom_range(0, 3));
      d       = ($urandom_range(0, 3) == 0) ? DW'($urandom) : '0;
      dn      = m_pend ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 63) == 0);
      cycle(op_s, md, d, dn, ne);
    end
    rst_req = 1'b1; en_req = 1'b1; clr_req = 1'b0;
    idle(2);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) settle();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
